spy_round_ctrl: RTL and testbench

Game-level sequencer for the Morse spy game. It enables player 1 code entry, then hands the guessing datapath to player 2. It tracks attempts and a per-round time limit, awards round points, and declares a game winner. It sits above the player1/player2 datapaths and drives their enable/clear strobes from their done/result/complete outputs.

---
 rtl/spy_game_pkg.sv | 34 +++
 rtl/round_timer.sv | 26 ++
 rtl/spy_round_ctrl.sv | 129 ++++++++++++
 tb/tb_spy_round_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spy_game_pkg.sv
// Shared encodings for the Morse spy game: FSM states, guess result codes,
// Morse symbol codes, winner codes and the round-outcome record.
package spy_game_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_P1_ENTRY  = 3'd1;
    localparam logic [2:0] ST_LATCH     = 3'd2;
    localparam logic [2:0] ST_P2_GUESS  = 3'd3;
    localparam logic [2:0] ST_ROUND_END = 3'd4;
    localparam logic [2:0] ST_GAME_OVER = 3'd5;

    // 2'b11 from the guess datapath is treated as neutral.
    localparam logic [1:0] RES_NEUTRAL   = 2'b00;
    localparam logic [1:0] RES_CORRECT   = 2'b01;
    localparam logic [1:0] RES_INCORRECT = 2'b10;

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_LINE = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef struct packed {
        logic p1_wins;
        logic p2_wins;
    } round_evt_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round countdown in tick pulses; expire flags the tick that consumes
// the last remaining unit so the sequencer can award the round.
module round_timer #(
    parameter int TIME_LIMIT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    output logic [5:0] count,
    output logic       expire
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 6'd0;
        end else if (load) begin
            count <= 6'(TIME_LIMIT);
        end else if (dec && count != 6'd0) begin
            count <= count - 6'd1;
        end
    end

    assign expire = dec && (count == 6'd1);

endmodule

// File: rtl/spy_round_ctrl.sv
// Game sequencer: player 1 enters a code, player 2 guesses against attempt
// and time limits, round points accumulate until one player reaches WIN_SCORE.
module spy_round_ctrl
    import spy_game_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 3,
    parameter int TIME_LIMIT   = 30,
    parameter int WIN_SCORE    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_done,
    input  logic [9:0] p1_value,
    input  logic [1:0] p2_result,
    input  logic       p2_complete,
    input  logic       tick,
    output logic       p1_en,
    output logic       p2_en,
    output logic       p2_clear,
    output logic       code_latch,
    output logic [1:0] attempts_left,
    output logic [5:0] time_left,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       round_over,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [3:0] WIN_LIM  = 4'(WIN_SCORE);
    localparam logic [1:0] ATT_INIT = 2'(MAX_ATTEMPTS);

    logic       in_guess;
    logic       wrong;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_expire;
    logic [2:0] next_state;
    round_evt_t evt;

    // Strobes are level outputs decoded from the registered next state, so
    // each one is high exactly for the cycle the FSM occupies its state.
    // p2_complete outranks everything: no counter moves on a player-2 win.
    assign in_guess   = (state == ST_P2_GUESS);
    assign wrong      = in_guess && !p2_complete && (p2_result == RES_INCORRECT);
    assign timer_dec  = in_guess && !p2_complete && tick;
    assign timer_load = (state == ST_P1_ENTRY) && p1_done && (p1_value != 10'd0);

    always_comb begin
        evt.p2_wins = in_guess && p2_complete;
        evt.p1_wins = (wrong && attempts_left == 2'd1) || timer_expire;
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:      next_state = start ? ST_P1_ENTRY : ST_IDLE;
            ST_P1_ENTRY:  next_state = timer_load ? ST_LATCH : ST_P1_ENTRY;
            ST_LATCH:     next_state = ST_P2_GUESS;
            ST_P2_GUESS:  next_state = (evt.p1_wins || evt.p2_wins) ? ST_ROUND_END : ST_P2_GUESS;
            ST_ROUND_END: next_state = (score_p1 == WIN_LIM || score_p2 == WIN_LIM)
                                       ? ST_GAME_OVER : ST_P1_ENTRY;
            ST_GAME_OVER: next_state = start ? ST_P1_ENTRY : ST_GAME_OVER;
            default:      next_state = ST_IDLE;
        endcase
    end

    round_timer #(
        .TIME_LIMIT(TIME_LIMIT)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (timer_load),
        .dec   (timer_dec),
        .count (time_left),
        .expire(timer_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            p1_en         <= 1'b0;
            p2_en         <= 1'b0;
            p2_clear      <= 1'b0;
            code_latch    <= 1'b0;
            round_over    <= 1'b0;
            attempts_left <= 2'd0;
            score_p1      <= 4'd0;
            score_p2      <= 4'd0;
            winner        <= WIN_NONE;
        end else begin
            state      <= next_state;
            p1_en      <= (next_state == ST_P1_ENTRY);
            p2_en      <= (next_state == ST_P2_GUESS);
            p2_clear   <= (next_state == ST_LATCH);
            code_latch <= (next_state == ST_LATCH);
            round_over <= (next_state == ST_ROUND_END);

            if (timer_load) begin
                attempts_left <= ATT_INIT;
            end else if (wrong && attempts_left != 2'd0) begin
                attempts_left <= attempts_left - 2'd1;
            end

            if (evt.p1_wins) begin
                score_p1 <= sat_inc(score_p1, WIN_LIM);
            end
            if (evt.p2_wins) begin
                score_p2 <= sat_inc(score_p2, WIN_LIM);
            end

            if (state == ST_ROUND_END) begin
                if (score_p1 == WIN_LIM) begin
                    winner <= WIN_P1;
                end else if (score_p2 == WIN_LIM) begin
                    winner <= WIN_P2;
                end
            end

            if (state == ST_GAME_OVER && start) begin
                score_p1 <= 4'd0;
                score_p2 <= 4'd0;
                winner   <= WIN_NONE;
            end
        end
    end

endmodule

// File: tb/tb_spy_round_ctrl.sv
// Bench for spy_round_ctrl: scripted round table, async reset check, then
// randomized play compared each cycle against a rule-level game model.
module tb_spy_round_ctrl;
    import spy_game_pkg::*;

    localparam int MAX_ATT = 3;
    localparam int TL      = 30;
    localparam int WS      = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       p1_done;
    logic [9:0] p1_value;
    logic [1:0] p2_result;
    logic       p2_complete;
    logic       tick;
    logic       p1_en;
    logic       p2_en;
    logic       p2_clear;
    logic       code_latch;
    logic [1:0] attempts_left;
    logic [5:0] time_left;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       round_over;
    logic [1:0] winner;
    logic [2:0] state;

    always #5 clock = ~clock;

    spy_round_ctrl #(
        .MAX_ATTEMPTS(MAX_ATT),
        .TIME_LIMIT  (TL),
        .WIN_SCORE   (WS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .p1_done      (p1_done),
        .p1_value     (p1_value),
        .p2_result    (p2_result),
        .p2_complete  (p2_complete),
        .tick         (tick),
        .p1_en        (p1_en),
        .p2_en        (p2_en),
        .p2_clear     (p2_clear),
        .code_latch   (code_latch),
        .attempts_left(attempts_left),
        .time_left    (time_left),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .round_over   (round_over),
        .winner       (winner),
        .state        (state)
    );

    // {p1_en,p2_en,p2_clear,code_latch,attempts,time,s1,s2,round_over,winner,state}
    logic [25:0] dut_out;
    assign dut_out = {p1_en, p2_en, p2_clear, code_latch, attempts_left, time_left,
                      score_p1, score_p2, round_over, winner, state};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: phase numbers follow the documented state codes.
    int m_st, m_att, m_tm, m_s1, m_s2, m_win;

    task automatic model_reset();
        m_st = 0; m_att = 0; m_tm = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
    endtask

    function automatic int sat_add(input int v);
        return (v + 1 > WS) ? WS : v + 1;
    endfunction

    task automatic model_step();
        bit lost;
        lost = 1'b0;
        case (m_st)
            0: if (start) m_st = 1;
            1: if (p1_done && p1_value != 10'd0) begin
                   m_st = 2; m_att = MAX_ATT; m_tm = TL;
               end
            2: m_st = 3;
            3: begin
                   if (p2_complete) begin
                       m_s2 = sat_add(m_s2); m_st = 4;
                   end else begin
                       if (p2_result == RES_INCORRECT) begin
                           if (m_att == 1) lost = 1'b1;
                           if (m_att > 0) m_att--;
                       end
                       if (tick) begin
                           if (m_tm == 1) lost = 1'b1;
                           if (m_tm > 0) m_tm--;
                       end
                       if (lost) begin
                           m_s1 = sat_add(m_s1); m_st = 4;
                       end
                   end
               end
            4: begin
                   if (m_s1 == WS) begin m_win = 1; m_st = 5; end
                   else if (m_s2 == WS) begin m_win = 2; m_st = 5; end
                   else m_st = 1;
               end
            5: if (start) begin
                   m_s1 = 0; m_s2 = 0; m_win = 0; m_st = 1;
               end
            default: m_st = 0;
        endcase
    endtask

    function automatic logic [25:0] model_out();
        logic p1e, p2e, la, ro;
        p1e = (m_st == 1);
        p2e = (m_st == 3);
        la  = (m_st == 2);
        ro  = (m_st == 4);
        return {p1e, p2e, la, la, 2'(m_att), 6'(m_tm), 4'(m_s1), 4'(m_s2), ro, 2'(m_win), 3'(m_st)};
    endfunction

    task automatic drive(input logic s, input logic d, input logic [9:0] v,
                         input logic [1:0] r, input logic c, input logic t);
        start = s; p1_done = d; p1_value = v; p2_result = r; p2_complete = c; tick = t;
    endtask

    task automatic step(input logic s, input logic d, input logic [9:0] v,
                        input logic [1:0] r, input logic c, input logic t);
        drive(s, d, v, r, c, t);
        @(posedge clock);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        s;
        logic        d;
        logic [9:0]  v;
        logic [1:0]  r;
        logic        c;
        logic        t;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [4:0] S_0  = 5'b00000;
    localparam logic [4:0] S_P1 = 5'b10000;
    localparam logic [4:0] S_P2 = 5'b01000;
    localparam logic [4:0] S_LA = 5'b00110;
    localparam logic [4:0] S_RE = 5'b00001;
    localparam logic [9:0] CODE = 10'b0111000000;

    task automatic add(input logic s, input logic d, input logic [9:0] v, input logic [1:0] r,
                       input logic c, input logic t, input int st, input int att, input int tm,
                       input int s1, input int s2, input logic [4:0] strb, input int win);
        vec_t x;
        x.s = s; x.d = d; x.v = v; x.r = r; x.c = c; x.t = t;
        x.exp = {strb[4:1], 2'(att), 6'(tm), 4'(s1), 4'(s2), strb[0], 2'(win), 3'(st)};
        vecs.push_back(x);
    endtask

    task automatic build_table();
        // IDLE ignores everything but start
        add(0, 1, CODE, RES_INCORRECT, 1, 1, 0, 0, 0, 0, 0, S_0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, S_P1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, S_P1, 0);
        add(0, 1, CODE, 0, 0, 0, 2, 3, 30, 0, 0, S_LA, 0);
        add(0, 0, 0, 0, 0, 0, 3, 3, 30, 0, 0, S_P2, 0);
        add(0, 0, 0, 2'b11, 0, 0, 3, 3, 30, 0, 0, S_P2, 0);
        add(0, 0, 0, RES_INCORRECT, 0, 0, 3, 2, 30, 0, 0, S_P2, 0);
        add(0, 0, 0, RES_INCORRECT, 0, 0, 3, 1, 30, 0, 0, S_P2, 0);
        add(0, 0, 0, RES_INCORRECT, 0, 0, 4, 0, 30, 1, 0, S_RE, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 30, 1, 0, S_P1, 0);
        // time-out round
        add(0, 1, CODE, 0, 0, 0, 2, 3, 30, 1, 0, S_LA, 0);
        add(0, 0, 0, 0, 0, 0, 3, 3, 30, 1, 0, S_P2, 0);
        for (int k = 1; k < TL; k++) add(0, 0, 0, 0, 0, 1, 3, 3, TL - k, 1, 0, S_P2, 0);
        add(0, 0, 0, 0, 0, 1, 4, 3, 0, 2, 0, S_RE, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3, 0, 2, 0, S_P1, 0);
        // tick and complete together: player 2 takes it
        add(0, 1, CODE, 0, 0, 0, 2, 3, 30, 2, 0, S_LA, 0);
        add(0, 0, 0, 0, 0, 0, 3, 3, 30, 2, 0, S_P2, 0);
        add(0, 0, 0, 0, 1, 1, 4, 3, 30, 2, 1, S_RE, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3, 30, 2, 1, S_P1, 0);
        // last attempt and last tick in the same cycle
        add(0, 1, CODE, 0, 0, 0, 2, 3, 30, 2, 1, S_LA, 0);
        add(0, 0, 0, 0, 0, 0, 3, 3, 30, 2, 1, S_P2, 0);
        add(0, 0, 0, RES_INCORRECT, 0, 0, 3, 2, 30, 2, 1, S_P2, 0);
        add(0, 0, 0, RES_INCORRECT, 0, 0, 3, 1, 30, 2, 1, S_P2, 0);
        for (int k = 1; k < TL; k++) add(0, 0, 0, 0, 0, 1, 3, 1, TL - k, 2, 1, S_P2, 0);
        add(0, 0, 0, RES_INCORRECT, 0, 1, 4, 0, 0, 3, 1, S_RE, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1, S_P1, 0);
        // player 2 takes rounds 2..5; start mid-guess is ignored
        for (int r = 2; r <= WS; r++) begin
            add(0, 1, CODE, 0, 0, 0, 2, 3, 30, 3, r - 1, S_LA, 0);
            add(1, 0, 0, 0, 0, 0, 3, 3, 30, 3, r - 1, S_P2, 0);
            add(0, 0, 0, RES_CORRECT, 1, 0, 4, 3, 30, 3, r, S_RE, 0);
            if (r < WS) add(0, 0, 0, 0, 0, 0, 1, 3, 30, 3, r, S_P1, 0);
            else        add(0, 0, 0, 0, 0, 0, 5, 3, 30, 3, r, S_0, 2);
        end
        add(0, 1, CODE, RES_INCORRECT, 1, 1, 5, 3, 30, 3, WS, S_0, 2);
        add(1, 0, 0, 0, 0, 0, 1, 3, 30, 0, 0, S_P1, 0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", dut_out, 26'd0);
        reset = 1'b0;

        build_table();
        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].d, vecs[i].v, vecs[i].r, vecs[i].c, vecs[i].t);
            check($sformatf("vec_%0d", i), dut_out, vecs[i].exp);
            check($sformatf("model_vec_%0d", i), dut_out, model_out());
        end

        // asynchronous reset in the middle of a guess phase
        step(0, 1, CODE, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("pre_reset_guess", dut_out, model_out());
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_mid_guess", dut_out, 26'd0);
        @(posedge clock);
        #1;
        check("reset_held", dut_out, 26'd0);
        reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            logic       rs, rd, rc, rt;
            logic [9:0] rv;
            logic [1:0] rr;
            rs = ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
            rr = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : RES_NEUTRAL;
            rc = ($urandom_range(0, 15) == 0);
            rt = ($urandom_range(0, 2) == 0);
            step(rs, rd, rv, rr, rc, rt);
            check($sformatf("rand_%0d", n), dut_out, model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
